// File: rtl/mem_access.sv
// Load/store unit between the execute stage and the data cache: IDLE -> REQ -> WAIT FSM.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN rejects misaligned ops instead of truncating the address.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        dcache_req,
   output logic        dcache_we,
   output logic [31:0] dcache_addr,
   output logic [31:0] dcache_wdata,
   output logic [3:0]  dcache_be,
   input  logic        dcache_ready,
   input  logic        dcache_rvalid,
   input  logic [31:0] dcache_rdata
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [29:0]     addr_q;
   logic [1:0]      off_q;
   logic [1:0]      size_q;
   logic            we_q;
   logic            uns_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic            dcache_req_q;
   logic            dcache_we_q;
   logic            load_valid_q;
   logic            misalign_q;
   logic            bus_err_q;
   logic [31:0]     load_data_q;

   logic            reject;
   logic [1:0]      off_d;
   logic [3:0]      be_d;
   logic [31:0]     wdata_d;
   logic [31:0]     lane;
   logic [31:0]     ext_d;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign reject = ((mem_size == 2'b01) & mem_addr[0]) | (mem_size[1] & (|mem_addr[1:0]));
`else
   assign reject = 1'b0;
`endif

   // Byte offset is forced to the natural alignment of the access size.
   always_comb begin
      off_d   = mem_addr[1:0];
      be_d    = 4'b0001;
      wdata_d = {24'b0, mem_wdata[7:0]};
      case (mem_size)
         2'b00: begin
            off_d   = mem_addr[1:0];
            be_d    = 4'b0001;
            wdata_d = {24'b0, mem_wdata[7:0]};
         end
         2'b01: begin
            off_d   = {mem_addr[1], 1'b0};
            be_d    = 4'b0011;
            wdata_d = {16'b0, mem_wdata[15:0]};
         end
         default: begin
            off_d   = 2'b00;
            be_d    = 4'b1111;
            wdata_d = mem_wdata;
         end
      endcase
      be_d    = be_d << off_d;
      wdata_d = wdata_d << {off_d, 3'b000};
   end

   always_comb begin
      lane  = dcache_rdata >> {off_q, 3'b000};
      ext_d = lane;
      case (size_q)
         2'b00:   ext_d = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'b01:   ext_d = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: ext_d = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         addr_q       <= '0;
         off_q        <= '0;
         size_q       <= '0;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
         dcache_req_q <= 1'b0;
         dcache_we_q  <= 1'b0;
         load_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
         load_data_q  <= '0;
      end else begin
         load_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (mem_valid) begin
                  if (reject) begin
                     misalign_q <= 1'b1;
                  end else begin
                     addr_q       <= mem_addr[31:2];
                     off_q        <= off_d;
                     size_q       <= mem_size;
                     we_q         <= mem_we;
                     uns_q        <= mem_unsigned;
                     wdata_q      <= wdata_d;
                     be_q         <= be_d;
                     dcache_req_q <= 1'b1;
                     dcache_we_q  <= mem_we;
                     state_q      <= StReq;
                  end
               end
            end
            StReq: begin
               if (dcache_ready) begin
                  dcache_req_q <= 1'b0;
                  dcache_we_q  <= 1'b0;
                  cnt_q        <= '0;
                  state_q      <= we_q ? StIdle : StWait;
               end
            end
            StWait: begin
               if (dcache_rvalid) begin
                  load_data_q  <= ext_d;
                  load_valid_q <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= StIdle;
               end else if (cnt_q == CntLast) begin
                  load_data_q <= '0;
                  bus_err_q   <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stall        = ((state_q == StIdle) & mem_valid & ~reject) | (state_q != StIdle);
   assign load_valid   = load_valid_q;
   assign load_data    = load_data_q;
   assign misalign     = misalign_q;
   assign bus_err      = bus_err_q;
   assign dcache_req   = dcache_req_q;
   assign dcache_we    = dcache_we_q;
   assign dcache_addr  = {addr_q, 2'b00};
   assign dcache_wdata = wdata_q;
   assign dcache_be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset corner sequences and random ops
// checked against a transaction-level model of size/offset/extension arithmetic.
module tb_mem_access;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_we, mem_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, load_valid, misalign, bus_err, dcache_req, dcache_we;
   logic [31:0] load_data, dcache_addr, dcache_wdata;
   logic [3:0]  dcache_be;
   logic        dcache_ready, dcache_rvalid;
   logic [31:0] dcache_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .stall        (stall),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .misalign     (misalign),
      .bus_err      (bus_err),
      .dcache_req   (dcache_req),
      .dcache_we    (dcache_we),
      .dcache_addr  (dcache_addr),
      .dcache_wdata (dcache_wdata),
      .dcache_be    (dcache_be),
      .dcache_ready (dcache_ready),
      .dcache_rvalid(dcache_rvalid),
      .dcache_rdata (dcache_rdata)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdly;
      int          vdly;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
      logic [31:0] exp_ld;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // ---- reference model: plain arithmetic on access width in bytes ----
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic int m_off(input logic [1:0] size, input logic [31:0] addr);
      int a;
      a = int'(addr % 4);
      return a - (a % nbytes(size));
   endfunction

   function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      return (addr % nbytes(size)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      int v;
      v = ((1 << nbytes(size)) - 1) << m_off(size, addr);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] addr,
                                           input logic [31:0] wd);
      logic [63:0] mask, v;
      mask = (64'd1 << (8 * nbytes(size))) - 64'd1;
      v = ({32'b0, wd} & mask) << (8 * m_off(size, addr));
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
      logic [63:0] mask, v;
      int nb;
      nb   = nbytes(size);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = ({32'b0, rd} >> (8 * m_off(size, addr))) & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one op through accept, REQ (rdly stalled cycles) and WAIT (rvalid after vdly).
   task automatic do_op(input vec_t v);
      logic [31:0] wm, exp_wd;
      wm     = be_mask(v.exp_be);
      exp_wd = m_wdata(v.size, v.addr, v.wdata);
      mem_valid = 1'b1; mem_we = v.we; mem_size = v.size; mem_unsigned = v.uns;
      mem_addr = v.addr; mem_wdata = v.wdata;
      @(negedge clk);
      chk("accept_stall", stall, !v.exp_mis);
      tick();
      mem_valid = 1'b0;
      if (v.exp_mis) begin
         @(negedge clk);
         chk("mis_pulse", misalign, 1);
         chk("mis_no_req", dcache_req, 0);
         chk("mis_stall", stall, 0);
         tick();
         @(negedge clk);
         chk("mis_pulse_end", misalign, 0);
         tick();
         return;
      end
      for (int k = 0; k <= v.rdly; k++) begin
         dcache_ready  = (k == v.rdly);
         dcache_rvalid = 1'b1;  // must be ignored outside WAIT
         dcache_rdata  = $urandom;
         @(negedge clk);
         chk("req_req", dcache_req, 1);
         chk("req_we", dcache_we, v.we);
         chk("req_addr", dcache_addr, v.exp_addr);
         chk("req_be", dcache_be, v.exp_be);
         chk("req_stall", stall, 1);
         chk("req_misalign", misalign, 0);
         if (v.we) chk("req_wdata", dcache_wdata & wm, exp_wd & wm);
         tick();
      end
      dcache_ready  = 1'b0;
      dcache_rvalid = 1'b0;
      if (v.we) begin
         @(negedge clk);
         chk("st_done_stall", stall, 0);
         chk("st_done_req", dcache_req, 0);
         chk("st_done_we", dcache_we, 0);
         tick();
         return;
      end
      for (int j = 0; j < int'(TO); j++) begin
         dcache_rvalid = (j == v.vdly);
         dcache_rdata  = (j == v.vdly) ? v.rdata : $urandom;
         @(negedge clk);
         chk("wait_stall", stall, 1);
         chk("wait_req", dcache_req, 0);
         chk("wait_lv", load_valid, 0);
         chk("wait_berr", bus_err, 0);
         tick();
         if (j == v.vdly) break;
      end
      dcache_rvalid = 1'b0;
      @(negedge clk);
      if (v.vdly < int'(TO)) begin
         chk("ld_valid", load_valid, 1);
         chk("ld_data", load_data, v.exp_ld);
         chk("ld_berr", bus_err, 0);
      end else begin
         chk("to_berr", bus_err, 1);
         chk("to_data", load_data, 0);
         chk("to_lv", load_valid, 0);
      end
      chk("ld_stall", stall, 0);
      tick();
      @(negedge clk);
      chk("pulse_end_lv", load_valid, 0);
      chk("pulse_end_berr", bus_err, 0);
      tick();
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int rdly, input int vdly,
                               input logic [3:0] exp_be, input logic [31:0] exp_addr,
                               input logic [31:0] exp_ld, input logic exp_mis);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.rdly = rdly; v.vdly = vdly; v.exp_be = exp_be; v.exp_addr = exp_addr;
      v.exp_ld = exp_ld; v.exp_mis = exp_mis;
      return v;
   endfunction

   initial begin
      vec_t rv;
      vecs[0] = mk(1, 2'd0, 0, 32'h1003, 32'h000000A5, 0, 0, 0, 4'b1000, 32'h1000, 0, 0);
      vecs[1] = mk(0, 2'd1, 0, 32'h2002, 0, 32'h80FF1234, 0, 0, 4'b1100, 32'h2000,
                   32'hFFFF80FF, 0);
      vecs[2] = mk(0, 2'd1, 1, 32'h2002, 0, 32'h80FF1234, 0, 0, 4'b1100, 32'h2000,
                   32'h000080FF, 0);
      vecs[3] = mk(0, 2'd2, 0, 32'h4000, 0, 32'hDEADBEEF, 5, 0, 4'b1111, 32'h4000,
                   32'hDEADBEEF, 0);
      vecs[4] = mk(0, 2'd2, 0, 32'h5000, 0, 32'h12345678, 0, TO, 4'b1111, 32'h5000, 0, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      vecs[5] = mk(0, 2'd2, 0, 32'h3001, 0, 32'hCAFEF00D, 0, 1, 4'b1111, 32'h3000,
                   32'hCAFEF00D, 1);
`else
      vecs[5] = mk(0, 2'd2, 0, 32'h3001, 0, 32'hCAFEF00D, 0, 1, 4'b1111, 32'h3000,
                   32'hCAFEF00D, 0);
`endif
      vecs[6] = mk(0, 2'd0, 1, 32'h6001, 0, 32'h11223344, 1, 2, 4'b0010, 32'h6000,
                   32'h00000033, 0);
      vecs[7] = mk(0, 2'd0, 0, 32'h6003, 0, 32'h80000000, 0, 3, 4'b1000, 32'h6000,
                   32'hFFFFFF80, 0);
      vecs[8] = mk(0, 2'd3, 1, 32'h7000, 0, 32'h12345678, 2, 2, 4'b1111, 32'h7000,
                   32'h12345678, 0);
      vecs[9] = mk(1, 2'd1, 0, 32'h8002, 32'hFFFFBEEF, 0, 1, 0, 4'b1100, 32'h8000, 0, 0);

      rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
      mem_addr = '0; mem_wdata = '0; dcache_ready = 1'b0; dcache_rvalid = 1'b0;
      dcache_rdata = '0;
      tick(); tick();
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_lv", load_valid, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_berr", bus_err, 0);
      chk("rst_req", dcache_req, 0);
      chk("rst_we", dcache_we, 0);
      chk("rst_ld", load_data, 0);
      chk("rst_addr", dcache_addr, 0);
      chk("rst_wdata", dcache_wdata, 0);
      chk("rst_be", dcache_be, 0);
      tick();
      rst = 1'b0;

      foreach (vecs[i]) do_op(vecs[i]);

      // Reset while waiting for read data, rvalid arriving right after: op is dropped.
      mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h9000;
      tick();
      mem_valid = 1'b0; dcache_ready = 1'b1;
      tick();
      dcache_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; dcache_rvalid = 1'b1; dcache_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      chk("rw_stall", stall, 0);
      chk("rw_lv", load_valid, 0);
      chk("rw_berr", bus_err, 0);
      chk("rw_req", dcache_req, 0);
      chk("rw_ld", load_data, 0);
      chk("rw_addr", dcache_addr, 0);
      chk("rw_be", dcache_be, 0);
      tick();
      dcache_rvalid = 1'b0;
      @(negedge clk);
      chk("rw_lv2", load_valid, 0);
      chk("rw_stall2", stall, 0);
      tick();

      // Reset while the request is outstanding: no completion afterwards.
      mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'hA000;
      tick();
      mem_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; dcache_ready = 1'b1;
      @(negedge clk);
      chk("rr_req", dcache_req, 0);
      chk("rr_stall", stall, 0);
      tick();
      dcache_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr_idle_stall", stall, 0);
         tick();
      end

      for (int n = 0; n < 150; n++) begin
         rv.we    = $urandom_range(0, 1);
         rv.size  = 2'($urandom_range(0, 3));
         rv.uns   = $urandom_range(0, 1);
         rv.addr  = $urandom;
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.rdly  = $urandom_range(0, 3);
         rv.vdly  = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 4));
         rv.exp_be   = m_be(rv.size, rv.addr);
         rv.exp_addr = {rv.addr[31:2], 2'b00};
         rv.exp_ld   = (rv.vdly < int'(TO)) ? m_load(rv.size, rv.uns, rv.addr, rv.rdata) : 0;
         rv.exp_mis  = m_mis(rv.size, rv.addr);
         do_op(rv);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            chk("gap_stall", stall, 0);
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the max cycles WAIT holds for dcache_rvalid before a bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_valid  input  1  execute stage presents a memory op this cycle.
REQ-005 mem_we  input  1  1 = store, 0 = load.
REQ-006 mem_size  input  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 treated as word.
REQ-007 mem_unsigned  input  1  zero-extend load result (funct3[2]).
REQ-008 mem_addr  input  32  byte address.
REQ-009 mem_wdata  input  32  store data, right-aligned.
REQ-010 stall  output  1  freeze upstream pipeline.
REQ-011 load_valid  output  1  one-cycle pulse, load_data valid.
REQ-012 load_data  output  32  aligned, extended load result.
REQ-013 misalign  output  1  one-cycle pulse, misaligned op rejected.
REQ-014 bus_err  output  1  one-cycle pulse, load timed out.
REQ-015 dcache_req  output  1  request to data cache.
REQ-016 dcache_we  output  1  request is a write.
REQ-017 dcache_addr  output  32  word address, bits [1:0] = 00.
REQ-018 dcache_wdata  output  32  lane-shifted store data.
REQ-019 dcache_be  output  4  byte enables (0001/0011/1111 shifted by addr[1:0]).
REQ-020 dcache_ready  input  1  cache accepts request this cycle.
REQ-021 dcache_rvalid  input  1  read data valid this cycle.
REQ-022 dcache_rdata  input  32  read word.

Function
REQ-023 FSM states IDLE, REQ, WAIT; mem_valid sampled only in IDLE.
REQ-024 IDLE & mem_valid (aligned): latch addr/size/we/unsigned/lane-shifted wdata/be, go REQ next cycle.
REQ-025 REQ: dcache_req=1 with latched fields held stable until dcache_ready; store & ready -> IDLE; load & ready -> WAIT.
REQ-026 WAIT: dcache_rvalid -> extract lane at latched addr[1:0], sign/zero-extend per size/unsigned, register into load_data, pulse load_valid, go IDLE.
REQ-027 WAIT counter increments each cycle; reaching TIMEOUT_CYCLES without rvalid -> bus_err pulse, load_data=0, IDLE, counter cleared.
REQ-028 stall = (IDLE & mem_valid & not rejected) | state!=IDLE; stall low in the cycle load_valid pulses.
REQ-029 Best-case latency: load accepted cycle N, ready at N+1, rvalid at N+2 -> load_valid at N+3; store completes (IDLE) at N+2.
REQ-030 dcache_req, dcache_we low outside REQ; dcache_rvalid outside WAIT ignored.
REQ-031 Word load returns rdata unshifted; size 11 behaves exactly as word.

Reset
REQ-032 rst=1 at a clock edge: state IDLE, counter 0, stall/load_valid/misalign/bus_err/dcache_req/dcache_we 0, load_data/dcache_addr/dcache_wdata 0, dcache_be 0000.
REQ-033 Reset mid-REQ or mid-WAIT aborts the op; no load_valid or bus_err issued for it.

Configuration
REQ-034 MEM_ACCESS_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 -> misalign pulse next cycle, no cache request, no stall beyond acceptance cycle.
REQ-035 MEM_ACCESS_MISALIGN_TRAP_EN undefined: misalign tied 0; address truncated to natural alignment (half: addr[0]=0, word: addr[1:0]=00) and op proceeds.

Verification
REQ-036 Store byte 0xA5 at 0x1003, ready immediate -> dcache_be=1000, dcache_wdata[31:24]=0xA5, dcache_addr=0x1000, IDLE two cycles after accept.
REQ-037 Load half signed at 0x2002, rdata=0x80FF1234 -> load_data=0xFFFF80FF; unsigned -> 0x000080FF; load_valid 3 cycles after accept.
REQ-038 Load word, dcache_ready low 5 cycles -> dcache_req and fields held stable 6 cycles, stall high throughout.
REQ-039 Load, no rvalid for 16 cycles -> bus_err pulse, load_data=0, IDLE, stall drops.
REQ-040 Word load at 0x3001: macro defined -> misalign pulse, no dcache_req; undefined -> request at 0x3000, be=1111.
REQ-041 rst asserted in WAIT, rvalid next cycle -> no load_valid, outputs at reset values.
